// File: rtl/peecc_pkg.sv
// Shared types and constants for the PEECC test-chain sequencer.
// Stage indices name the datapath enable bits driven by pipe_seq_ctrl.
package peecc_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_FILL  = 3'd1,
    SEQ_RUN   = 3'd2,
    SEQ_DRAIN = 3'd3,
    SEQ_TX    = 3'd4
  } seq_state_t;

  localparam int SEQ_CNT_W = 11;

  localparam int STAGE_GEN = 0;
  localparam int STAGE_ENC = 1;
  localparam int STAGE_BUS = 2;
  localparam int STAGE_DEC = 3;
  localparam int STAGE_CMP = 4;

endpackage

// File: rtl/seq_ramp_cnt.sv
// Step/dwell counter shared by the FILL and DRAIN ramps.
// Wraps to step 0 on expire so the next ramp starts clean.
module seq_ramp_cnt #(
  parameter int NUM_STAGES   = 5,
  parameter int STAGE_CYCLES = 2,
  localparam int SW = $clog2(NUM_STAGES),
  localparam int DW = $clog2(STAGE_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [SW-1:0] step,
  output logic          step_end,
  output logic          expire
);

  logic [DW-1:0] dwell;

  assign step_end = dwell == DW'(STAGE_CYCLES - 1);
  assign expire   = step_end && (step == SW'(NUM_STAGES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step  <= '0;
      dwell <= '0;
    end else if (clr) begin
      step  <= '0;
      dwell <= '0;
    end else if (en) begin
      if (step_end) begin
        dwell <= '0;
        step  <= expire ? '0 : step + 1'b1;
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_seq_ctrl.sv
// PEECC pipeline sequencer: FILL ramp, RUN burst, DRAIN ramp, TX handoff.
// Optional perf counters are built when PEECC_SEQ_PERF_EN is defined.
module pipe_seq_ctrl
  import peecc_pkg::*;
#(
  parameter int NUM_STAGES   = 5,
  parameter int STAGE_CYCLES = 2,
  parameter int CNT_W        = SEQ_CNT_W,
  parameter int TRIG_CYCLES  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [CNT_W-1:0]      cfg_burst_len,
  input  logic                  cfg_continuous,
  input  logic                  abort,
  input  logic                  tx_done,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  trigger,
  output logic                  start_tx,
  output logic                  done,
  output logic                  aborted,
  output logic                  busy,
  output logic [2:0]            state_o
`ifdef PEECC_SEQ_PERF_EN
  ,
  output logic [15:0]           perf_runs,
  output logic [31:0]           perf_cycles
`endif
);

  localparam int SW = $clog2(NUM_STAGES);

  seq_state_t state;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] lat_len;
  logic [SW-1:0] step;
  logic step_end;
  logic expire;
  logic ramp_clr;
  logic [NUM_STAGES-1:0] nxt_bit;

  assign state_o  = state;
  assign lat_len  = (cfg_burst_len == '0) ? CNT_W'(1) : cfg_burst_len;
  assign ramp_clr = abort ||
    !(state == SEQ_FILL || state == SEQ_DRAIN);
  // Bit that the ramp touches when the current step ends.
  assign nxt_bit  = NUM_STAGES'(2) << step;

  seq_ramp_cnt #(
    .NUM_STAGES   (NUM_STAGES),
    .STAGE_CYCLES (STAGE_CYCLES)
  ) u_ramp (
    .clk      (clk),
    .reset    (reset),
    .clr      (ramp_clr),
    .en       (!ramp_clr),
    .step     (step),
    .step_end (step_end),
    .expire   (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SEQ_IDLE;
      stage_en <= '0;
      trigger  <= 1'b0;
      start_tx <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      busy     <= 1'b0;
      len      <= CNT_W'(1);
      run_cnt  <= '0;
    end else begin
      start_tx <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      if (abort && state != SEQ_IDLE) begin
        state    <= SEQ_IDLE;
        stage_en <= '0;
        trigger  <= 1'b0;
        busy     <= 1'b0;
        aborted  <= 1'b1;
      end else begin
        unique case (state)
          SEQ_IDLE: begin
            if (valid_in) begin
              state    <= SEQ_FILL;
              stage_en <= NUM_STAGES'(1);
              busy     <= 1'b1;
              len      <= lat_len;
            end
          end
          SEQ_FILL: begin
            if (expire) begin
              state    <= SEQ_RUN;
              stage_en <= '1;
              trigger  <= 1'b1;
              run_cnt  <= CNT_W'(1);
            end else if (step_end) begin
              stage_en <= stage_en | nxt_bit;
            end
          end
          SEQ_RUN: begin
            if (run_cnt == len) begin
              state    <= SEQ_DRAIN;
              stage_en <= ~NUM_STAGES'(1);
              trigger  <= 1'b0;
            end else begin
              run_cnt <= run_cnt + 1'b1;
              trigger <= 32'(run_cnt) < TRIG_CYCLES;
            end
          end
          SEQ_DRAIN: begin
            if (expire) begin
              state    <= SEQ_TX;
              start_tx <= 1'b1;
              done     <= 1'b1;
            end else if (step_end) begin
              stage_en <= stage_en & ~nxt_bit;
            end
          end
          SEQ_TX: begin
            if (tx_done) begin
              if (cfg_continuous && valid_in) begin
                state    <= SEQ_FILL;
                stage_en <= NUM_STAGES'(1);
                len      <= lat_len;
              end else begin
                state <= SEQ_IDLE;
                busy  <= 1'b0;
              end
            end
          end
          default: begin
            state    <= SEQ_IDLE;
            stage_en <= '0;
            trigger  <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PEECC_SEQ_PERF_EN
  logic tx_entry;

  assign tx_entry = state == SEQ_DRAIN && expire && !abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_runs   <= '0;
      perf_cycles <= '0;
    end else begin
      if (tx_entry && perf_runs != '1)
        perf_runs <= perf_runs + 1'b1;
      if (busy && perf_cycles != '1)
        perf_cycles <= perf_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Bench for pipe_seq_ctrl: phase/offset reference model plus directed
// scenario checks and a randomized soak.
module tb_pipe_seq_ctrl;

  localparam int N  = 5;
  localparam int S  = 2;
  localparam int T  = 3;
  localparam int CW = 11;
  localparam int M_IDLE  = 0;
  localparam int M_FILL  = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;
  localparam int M_TX    = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid_in = 1'b0;
  logic cfg_continuous = 1'b0;
  logic abort = 1'b0;
  logic tx_done = 1'b0;
  logic [CW-1:0] cfg_burst_len = '0;
  logic [N-1:0] stage_en;
  logic trigger, start_tx, done, aborted, busy;
  logic [2:0] state_o;
`ifdef PEECC_SEQ_PERF_EN
  logic [15:0] perf_runs;
  logic [31:0] perf_cycles;
`endif

  int vecs = 0;
  int fails = 0;

  int m_st, m_c, m_L;
  bit m_ab;
  longint m_runs, m_cyc;

  always #5 clk = ~clk;

  pipe_seq_ctrl #(
    .NUM_STAGES   (N),
    .STAGE_CYCLES (S),
    .CNT_W        (CW),
    .TRIG_CYCLES  (T)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_in       (valid_in),
    .cfg_burst_len  (cfg_burst_len),
    .cfg_continuous (cfg_continuous),
    .abort          (abort),
    .tx_done        (tx_done),
    .stage_en       (stage_en),
    .trigger        (trigger),
    .start_tx       (start_tx),
    .done           (done),
    .aborted        (aborted),
    .busy           (busy),
    .state_o        (state_o)
`ifdef PEECC_SEQ_PERF_EN
    ,
    .perf_runs      (perf_runs),
    .perf_cycles    (perf_cycles)
`endif
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_c = 0; m_L = 1; m_ab = 0;
    m_runs = 0; m_cyc = 0;
  endtask

  // Phase + offset-in-phase view; outputs derive from durations.
  task automatic model_edge();
    m_ab = 0;
    if (m_st != M_IDLE) m_cyc++;
    if (m_st != M_IDLE && abort) begin
      m_st = M_IDLE; m_c = 0; m_ab = 1;
    end else begin
      case (m_st)
        M_IDLE: if (valid_in) begin
          m_st = M_FILL; m_c = 0;
          m_L = (cfg_burst_len == 0) ? 1 : int'(cfg_burst_len);
        end
        M_FILL: begin
          m_c++;
          if (m_c == N*S) begin m_st = M_RUN; m_c = 0; end
        end
        M_RUN: begin
          m_c++;
          if (m_c == m_L) begin m_st = M_DRAIN; m_c = 0; end
        end
        M_DRAIN: begin
          m_c++;
          if (m_c == N*S) begin
            m_st = M_TX; m_c = 0; m_runs++;
          end
        end
        default: begin
          if (tx_done) begin
            if (cfg_continuous && valid_in) begin
              m_st = M_FILL; m_c = 0;
              m_L = (cfg_burst_len == 0) ? 1 : int'(cfg_burst_len);
            end else begin
              m_st = M_IDLE; m_c = 0;
            end
          end else m_c++;
        end
      endcase
    end
  endtask

  function automatic int exp_en();
    int all = (1 << N) - 1;
    case (m_st)
      M_FILL:  return (1 << (m_c/S + 1)) - 1;
      M_RUN:   return all;
      M_DRAIN: return (all << (m_c/S + 1)) & all;
      default: return 0;
    endcase
  endfunction

  task automatic check_all();
    chk("stage_en", 32'(stage_en), exp_en());
    chk("trigger", 32'(trigger), 32'(m_st == M_RUN && m_c < T));
    chk("start_tx", 32'(start_tx), 32'(m_st == M_TX && m_c == 0));
    chk("done", 32'(done), 32'(m_st == M_TX && m_c == 0));
    chk("aborted", 32'(aborted), 32'(m_ab));
    chk("busy", 32'(busy), 32'(m_st != M_IDLE));
    chk("state_o", 32'(state_o), m_st);
`ifdef PEECC_SEQ_PERF_EN
    chk("perf_runs", 32'(perf_runs),
        (m_runs > 65535) ? 32'hFFFF : 32'(m_runs));
    chk("perf_cycles", perf_cycles, 32'(m_cyc));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    #3;
    reset = 1'b0;
  endtask

  task automatic idle_inputs();
    valid_in = 0; abort = 0; tx_done = 0; cfg_continuous = 0;
  endtask

  initial begin
    int cyc, st_cyc, n_trig, n_run, n_st;

    #3;
    do_reset();

    // Nominal run: burst 4, tx_done in cycle 27.
    cfg_burst_len = 4; valid_in = 1;
    tick(); cyc = 1; valid_in = 0; st_cyc = -1;
    while (cyc < 30) begin
      tx_done = (cyc == 27);
      tick(); cyc++;
      if (start_tx === 1'b1 && st_cyc < 0) st_cyc = cyc;
      if (cyc == 12) chk("nom_full", 32'(stage_en), 32'h1F);
      if (cyc == 13) chk("nom_trig13", 32'(trigger), 1);
      if (cyc == 14) chk("nom_trig14", 32'(trigger), 0);
      if (cyc == 15) chk("nom_drain1", 32'(stage_en), 32'h1E);
      if (cyc == 24) chk("nom_drain_end", 32'(stage_en), 0);
      if (cyc == 28) chk("nom_idle", 32'(busy), 0);
    end
    chk("nom_start_cyc", st_cyc, 25);
    tx_done = 0;

    // Burst length 0 behaves as 1.
    cfg_burst_len = 0; valid_in = 1; tx_done = 1;
    tick(); valid_in = 0; n_trig = 0; n_run = 0;
    repeat (30) begin
      tick();
      if (trigger === 1'b1) n_trig++;
      if (state_o === 3'd2) n_run++;
    end
    chk("b0_trig_cycles", n_trig, 1);
    chk("b0_run_cycles", n_run, 1);
    tx_done = 0;

    // Abort in RUN at cycle 12.
    cfg_burst_len = 4; valid_in = 1;
    tick(); cyc = 1; valid_in = 0; n_st = 0;
    while (cyc < 20) begin
      abort = (cyc == 12);
      tick(); cyc++;
      if (start_tx === 1'b1) n_st++;
      if (cyc == 13) begin
        chk("ab_state", 32'(state_o), 0);
        chk("ab_en", 32'(stage_en), 0);
        chk("ab_pulse", 32'(aborted), 1);
      end
      if (cyc == 14) chk("ab_pulse_end", 32'(aborted), 0);
    end
    chk("ab_no_tx", n_st, 0);
    abort = 0;

    // Continuous mode: relatch burst 6 on the TX->FILL turn.
    cfg_continuous = 1; valid_in = 1; tx_done = 1;
    cfg_burst_len = 4;
    tick(); cyc = 1; cfg_burst_len = 6; n_run = 0;
    while (cyc < 60) begin
      tick(); cyc++;
      if (state_o === 3'd2) n_run++;
      if (cyc == 26) begin
        chk("cont_refill_st", 32'(state_o), 1);
        chk("cont_refill_en", 32'(stage_en), 1);
      end
    end
    chk("cont_run_cycles", n_run, 10);
    cfg_continuous = 0; valid_in = 0;
    repeat (30) tick();
    chk("cont_idle", 32'(busy), 0);
    tx_done = 0;

    // Asynchronous reset in the middle of DRAIN.
    cfg_burst_len = 2; valid_in = 1;
    tick(); cyc = 1; valid_in = 0;
    while (cyc < 16) begin tick(); cyc++; end
    chk("rst_pre_drain", 32'(state_o), 3);
    do_reset();
    chk("rst_en", 32'(stage_en), 0);
    chk("rst_state", 32'(state_o), 0);
    valid_in = 1;
    tick();
    chk("rst_refill", 32'(stage_en), 1);
    valid_in = 0; tx_done = 1;
    repeat (30) tick();
    tx_done = 0;

    // Longest burst must run its full length.
    cfg_burst_len = '1; valid_in = 1; tx_done = 1;
    tick(); valid_in = 0; n_run = 0;
    repeat (2080) begin
      tick();
      if (state_o === 3'd2) n_run++;
    end
    chk("max_run_cycles", n_run, 2047);
    idle_inputs();

`ifdef PEECC_SEQ_PERF_EN
    // Two full runs and one abort after a fresh reset.
    @(posedge clk); #1;
    do_reset();
    cfg_burst_len = 4; tx_done = 1;
    repeat (2) begin
      valid_in = 1; tick(); valid_in = 0;
      repeat (27) tick();
    end
    tx_done = 0;
    valid_in = 1; tick(); cyc = 1; valid_in = 0;
    while (cyc < 16) begin
      abort = (cyc == 12);
      tick(); cyc++;
    end
    abort = 0;
    chk("perf_runs_2", 32'(perf_runs), 2);
    chk("perf_cycles_62", perf_cycles, 62);
`endif

    // Randomized soak against the model.
    repeat (1500) begin
      valid_in = $urandom_range(0, 9) < 3;
      abort = $urandom_range(0, 99) < 3;
      tx_done = $urandom_range(0, 9) < 4;
      cfg_continuous = 1'($urandom_range(0, 1));
      cfg_burst_len = CW'($urandom_range(0, 7));
      tick();
    end
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/pipe_seq_ctrl.md
Name: pipe_seq_ctrl

Overview:
Parametrised pipeline sequencer that drives the datapath stage enables (gen, enc, bus, dec, count/compare, ...) for the PEECC test chain. It ramps the stages on one at a time (FILL), holds all stages for a configurable burst (RUN), then ramps them off in order (DRAIN). It then hands off to the UART/TX path with a start_tx/tx_done handshake. It adds configurable stage count and timing, burst length, continuous mode and abort.

Parameters:
NUM_STAGES, 5, number of pipeline stage enables (>=2)
STAGE_CYCLES, 2, cycles each ramp step lasts in FILL/DRAIN (>=1)
CNT_W, 11, width of the burst counter and cfg_burst_len
TRIG_CYCLES, 3, cycles trigger is high at the start of RUN (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
valid_in  in  1  start request; sampled in IDLE, and in TX when continuous
cfg_burst_len  in  CNT_W  RUN length in cycles; latched on the IDLE/TX->FILL transition; 0 treated as 1
cfg_continuous  in  1  1: re-enter FILL after tx_done if valid_in is high
abort  in  1  synchronous abort, any non-IDLE state
tx_done  in  1  TX path finished; honoured only in TX
stage_en  out  NUM_STAGES  registered per-stage enables; bit0 = first stage
trigger  out  1  high for the first min(TRIG_CYCLES, burst) cycles of RUN
start_tx  out  1  1-cycle pulse in the first TX cycle
done  out  1  1-cycle pulse, coincident with start_tx
aborted  out  1  1-cycle pulse in the cycle after abort is sampled
busy  out  1  high in any state except IDLE
state_o  out  3  current state encoding

Behaviour:
- Reset: state=IDLE; every output 0; counters 0; latched burst length = 1.
- States: IDLE=0, FILL=1, RUN=2, DRAIN=3, TX=4. Other encodings go to IDLE.
- All outputs are registered. Any value described "in cycle n" is visible in the cycle after the causing edge.
- IDLE: when valid_in=1 at an edge, enter FILL. In the first FILL cycle, stage_en=...0001.
- FILL:
  - Step index k runs 0..NUM_STAGES-1. stage_en[k:0]=1.
  - k advances every STAGE_CYCLES cycles.
  - After the last step expires, enter RUN. FILL lasts exactly NUM_STAGES*STAGE_CYCLES cycles.
- RUN:
  - stage_en = all ones for exactly the latched burst length L cycles, then enter DRAIN.
  - trigger=1 during RUN cycles 1..min(TRIG_CYCLES, L), and 0 everywhere else.
- DRAIN:
  - In the first DRAIN cycle, bit0 clears. Bit j clears at DRAIN cycle j*STAGE_CYCLES+1.
  - One extra STAGE_CYCLES step with all bits zero follows. DRAIN lasts NUM_STAGES*STAGE_CYCLES cycles, then enter TX.
- TX:
  - stage_en=0. start_tx=done=1 in the first TX cycle only.
  - Waits for tx_done, which may arrive in the first TX cycle.
  - On tx_done: if cfg_continuous=1 and valid_in=1 at the same edge, go to FILL and relatch cfg_burst_len; otherwise go to IDLE.
- abort=1 in FILL/RUN/DRAIN/TX: next state is IDLE, stage_en=0, trigger=0. No start_tx/done pulse. aborted pulses once. abort has priority over tx_done and valid_in. In IDLE, abort is ignored and no pulse is produced.
- valid_in is ignored in FILL/RUN/DRAIN. cfg changes after the latch have no effect until the next latch.
- The burst counter is CNT_W bits and never wraps: L = 2^CNT_W-1 runs fully.
- Asynchronous reset mid-operation returns immediately to IDLE with all outputs 0. No TX pulse is generated.

Optional Feature:
- Macro PEECC_SEQ_PERF_EN.
- Defined: adds ports perf_runs (out, 16) and perf_cycles (out, 32).
  - perf_runs counts completed TX entries and saturates at 0xFFFF.
  - perf_cycles counts cycles with busy=1 and saturates.
  - Both are cleared by reset only. They are unaffected by abort.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package peecc_pkg holds:
  - state encodings SEQ_IDLE..SEQ_TX
  - default widths (CNT_W=11)
  - the STAGE_* index constants naming each datapath enable bit
- One sub-module, seq_ramp_cnt: step/dwell counter producing a step index and an expire strobe. It is reused by FILL and DRAIN.
- The top level holds the FSM, burst counter and pulses.

Test Plan:
All scenarios use NUM_STAGES=5, STAGE_CYCLES=2, TRIG_CYCLES=3.
- Nominal run: valid_in at cycle 0, burst=4, tx_done at cycle 27 ->
  - stage_en 00001 in cycles 1-2, 00011 in 3-4, 00111 in 5-6, 01111 in 7-8, 11111 in 9-14
  - trigger high in cycles 11-13
  - DRAIN: 11110 in 15-16, 11100 in 17-18, 11000 in 19-20, 10000 in 21-22, 00000 in 23-24
  - start_tx=done=1 in cycle 25 only; IDLE and busy=0 from cycle 28
- burst=0 -> RUN lasts 1 cycle; trigger high for 1 cycle; DRAIN begins on the next cycle.
- Abort in RUN (cycle 12) -> stage_en=0 and state IDLE in cycle 13; aborted=1 in cycle 13 only; start_tx never asserts.
- Continuous mode: cfg_continuous=1, valid_in held high, tx_done in the first TX cycle -> FILL re-entered the next cycle with stage_en=00001; new cfg_burst_len=6 gives 6 RUN cycles.
- Reset asserted mid-DRAIN -> all outputs 0 immediately. After release, valid_in=1 restarts a full FILL sequence from 00001.
- PEECC_SEQ_PERF_EN: two nominal runs plus one abort -> perf_runs=2; perf_cycles equals the total number of busy cycles.
